// File: rtl/disp_scan_pkg.sv
// Shared constants, mode type and width helper for the display scanner.
package disp_scan_pkg;

  localparam int CH_MAX = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int IDX_W = clog2(CH_MAX);

  localparam logic [CH_MAX-1:0] AN_OFF     = '1;
  localparam logic              DOUT_BLANK = 1'b0;

  typedef enum logic [1:0] {
    AN_LIT,
    AN_DEAD,
    AN_BLANK
  } an_mode_e;

endpackage

// File: rtl/disp_scan_mux_prescaler.sv
// Slot prescaler: counts DIV enabled cycles per slot and flags the last one.
module scan_prescaler
  import disp_scan_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [clog2(DIV)-1:0]  cnt,
  output logic                   slot_end
);

  localparam int               CNT_W = clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a corrupted count still closes the slot.
  assign slot_end = en && (cnt_q >= LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed display scanner with per-channel blanking and a scan freeze.
// Define SCAN_DEADTIME_EN to keep the anodes off for the first DEAD cycles of each slot.
module disp_scan_mux
  import disp_scan_pkg::*;
#(
  parameter int CH   = 6,
  parameter int W    = 4,
  parameter int DIV  = 16,
  parameter int DEAD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CH*W-1:0]       d,
  input  logic [CH-1:0]         blank_mask,
  output logic [W-1:0]          dout,
  output logic [clog2(CH)-1:0]  sel,
  output logic [CH-1:0]         an,
  output logic                  scan_tick
);

  localparam int SEL_W = clog2(CH);
  localparam int CNT_W = clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  logic [W-1:0]     ch_data [CH];
  logic [CH-1:0]    onehot_n;
  logic [SEL_W-1:0] idx_q, idx_d, idx_safe;
  logic             idx_valid, blanked, in_dead;
  an_mode_e         an_mode;

  logic [W-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CH-1:0]    an_q, an_d;
  logic             tick_q, tick_d;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign ch_data[gi]  = d[gi*W +: W];
    assign onehot_n[gi] = (IDX_W'(gi) != IDX_W'(idx_q));
  end

  // Out-of-range index (non power-of-two CH) is treated as blank and recovered to 0.
  assign idx_valid = ({{(32-SEL_W){1'b0}}, idx_q} < 32'(CH));
  assign idx_safe  = idx_valid ? idx_q : '0;
  assign blanked   = blank_mask[idx_safe];
  assign in_dead   = (cnt < CNT_W'(DEAD));

`ifndef SCAN_DEADTIME_EN
  logic unused_dead;
  assign unused_dead = in_dead;
`endif

  always_comb begin
    an_mode = AN_LIT;
    if (!idx_valid || blanked) begin
      an_mode = AN_BLANK;
    end
`ifdef SCAN_DEADTIME_EN
    else if (in_dead) begin
      an_mode = AN_DEAD;
    end
`endif
  end

  always_comb begin
    idx_d = idx_q;
    if (!idx_valid) begin
      idx_d = '0;
    end else if (slot_end) begin
      idx_d = (idx_q == SEL_W'(CH - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Output stage follows idx by one cycle; the count of zero marks a slot's first display cycle.
  always_comb begin
    sel_d  = sel_q;
    dout_d = dout_q;
    an_d   = an_q;
    tick_d = 1'b0;
    if (en) begin
      sel_d  = idx_q;
      tick_d = (cnt == '0);
      dout_d = (an_mode == AN_BLANK) ? {W{DOUT_BLANK}} : ch_data[idx_safe];
      an_d   = (an_mode == AN_LIT) ? onehot_n : AN_OFF[CH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      sel_q  <= '0;
      dout_q <= '0;
      an_q   <= AN_OFF[CH-1:0];
      tick_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      dout_q <= dout_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign dout      = dout_q;
  assign sel       = sel_q;
  assign an        = an_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux: a slot-position model predicts each cycle's outputs.
module tb_disp_scan_mux;

  localparam int CH   = 6;
  localparam int W    = 4;
  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] d;
  logic [5:0]  blank_mask;
  logic [3:0]  dout;
  logic [2:0]  sel;
  logic [5:0]  an;
  logic        scan_tick;

  always #5 clk = ~clk;

  disp_scan_mux #(
    .CH   (CH),
    .W    (W),
    .DIV  (DIV),
    .DEAD (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .d          (d),
    .blank_mask (blank_mask),
    .dout       (dout),
    .sel        (sel),
    .an         (an),
    .scan_tick  (scan_tick)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] an;
    logic [3:0] dout;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t model_out;
  int   pos;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL cyc=%0d %s: got %0h want %0h", cyc, name, act, req);
    end
  endtask

  // Enabled cycles since reset fix the channel and the position inside its slot.
  task automatic model_step(input logic r, input logic e, input logic [23:0] dd,
                            input logic [5:0] bm);
    int ch;
    int ph;
    logic [5:0] one;
    if (!r) begin
      pos       = 0;
      model_out = '{sel: 3'd0, an: 6'h3F, dout: 4'h0, tick: 1'b0};
    end else if (e) begin
      ch = (pos / DIV) % CH;
      ph = pos % DIV;
      one = 6'd1;
      model_out.sel  = 3'(ch);
      model_out.tick = (ph == 0);
      if (bm[ch]) begin
        model_out.an   = 6'h3F;
        model_out.dout = 4'h0;
      end else begin
        model_out.dout = dd[ch*W +: W];
        model_out.an   = ~(one << ch);
`ifdef SCAN_DEADTIME_EN
        if (ph < DEAD) model_out.an = 6'h3F;
`endif
      end
      pos++;
    end else begin
      model_out.tick = 1'b0;
    end
    exp_q.push_back(model_out);
  endtask

  task automatic drive(input logic r, input logic e, input logic [23:0] dd, input logic [5:0] bm);
    @(negedge clk);
    rst_n      = r;
    en         = e;
    d          = dd;
    blank_mask = bm;
    model_step(r, e, dd, bm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        $display("cyc=%0d rst_n=%b en=%b bm=%b sel=%0d an=%b dout=%h tick=%b", cyc, rst_n, en,
                 blank_mask, sel, an, dout, scan_tick);
        check("sel", 8'(sel), 8'(e.sel));
        check("an", 8'(an), 8'(e.an));
        check("dout", 8'(dout), 8'(e.dout));
        check("scan_tick", 8'(scan_tick), 8'(e.tick));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [23:0] d_r;
    logic [5:0]  bm_r;
    logic        r_r;
    logic        e_r;
    rst_n      = 1'b0;
    en         = 1'b0;
    d          = '0;
    blank_mask = '0;

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 24'h543210, 6'h00);
    for (int i = 0; i < 48; i++) drive(1'b1, 1'b1, 24'h543210, 6'h00);
    for (int i = 0; i < 24; i++) drive(1'b1, 1'b1, 24'h543210, 6'b000100);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 24'h543210, 6'h00);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 24'h543210, 6'h00);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 24'h543210, 6'h00);
    drive(1'b0, 1'b1, 24'h543210, 6'h00);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 24'h543210, 6'h00);

    d_r  = 24'hA5C3E1;
    bm_r = 6'h00;
    for (int i = 0; i < 600; i++) begin
      r_r = ($urandom_range(0, 99) >= 2);
      e_r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) d_r = 24'($urandom);
      if ($urandom_range(0, 31) == 0) bm_r = 6'($urandom) & 6'($urandom);
      drive(r_r, e_r, d_r, bm_r);
    end

    repeat (3) @(negedge clk);
    check("drain", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
